// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with write-back bypass on the register-file
// read operands, load-use hazard detection and bubble/flush insertion.
module id_ex_stage #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [AW-1:0]   id_rs1,
  input  logic [AW-1:0]   id_rs2,
  input  logic [AW-1:0]   id_rd,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic [XLEN-1:0] id_imm,
  input  logic [XLEN-1:0] id_pc,
  input  logic [8:0]      id_ctrl,
  input  logic [XLEN-1:0] rf_rdata1,
  input  logic [XLEN-1:0] rf_rdata2,
  input  logic            wb_regWrite,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            hazard_stall,
  output logic            ex_valid,
  output logic [AW-1:0]   ex_rs1,
  output logic [AW-1:0]   ex_rs2,
  output logic [AW-1:0]   ex_rd,
  output logic [XLEN-1:0] ex_op1,
  output logic [XLEN-1:0] ex_op2,
  output logic [XLEN-1:0] ex_imm,
  output logic [XLEN-1:0] ex_pc,
  output logic [8:0]      ex_ctrl
);

  localparam int MEMRD = 7;

  typedef struct packed {
    logic            valid;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [8:0]      ctrl;
  } id_ex_t;

  id_ex_t ex_q;
  id_ex_t ex_d;
  id_ex_t id_b;

  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic            hit1;
  logic            hit2;

  // Register file commits on the edge, so a same-cycle write must win.
  function automatic logic [XLEN-1:0] bypass(
    input logic [AW-1:0]   rs,
    input logic [XLEN-1:0] rf,
    input logic            we,
    input logic [AW-1:0]   wrd,
    input logic [XLEN-1:0] wdat
  );
    logic [XLEN-1:0] r;
    if (we && wrd != '0 && wrd == rs)
      r = wdat;
    else if (rs == '0)
      r = '0;
    else
      r = rf;
    return r;
  endfunction

  always_comb begin
    op1 = bypass(id_rs1, rf_rdata1,
                 wb_regWrite, wb_rd, wb_data);
    op2 = bypass(id_rs2, rf_rdata2,
                 wb_regWrite, wb_rd, wb_data);
  end

  always_comb begin
    hit1 = id_use_rs1 && (ex_q.rd == id_rs1);
    hit2 = id_use_rs2 && (ex_q.rd == id_rs2);
    hazard_stall = id_valid && ex_q.valid
                && ex_q.ctrl[MEMRD]
                && (ex_q.rd != '0)
                && (hit1 || hit2);
  end

  always_comb begin
    id_b.valid = id_valid;
    id_b.rs1   = id_rs1;
    id_b.rs2   = id_rs2;
    id_b.rd    = id_rd;
    id_b.op1   = op1;
    id_b.op2   = op2;
    id_b.imm   = id_imm;
    id_b.pc    = id_pc;
    id_b.ctrl  = id_valid ? id_ctrl : '0;
  end

  // Bubbles (flush or hazard) are fully zeroed for determinism.
  always_comb begin
    ex_d = ex_q;
    if (flush)
      ex_d = '0;
    else if (stall)
      ex_d = ex_q;
    else if (hazard_stall)
      ex_d = '0;
    else
      ex_d = id_b;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      ex_q <= '0;
    else
      ex_q <= ex_d;
  end

  assign ex_valid = ex_q.valid;
  assign ex_rs1   = ex_q.rs1;
  assign ex_rs2   = ex_q.rs2;
  assign ex_rd    = ex_q.rd;
  assign ex_op1   = ex_q.op1;
  assign ex_op2   = ex_q.op2;
  assign ex_imm   = ex_q.imm;
  assign ex_pc    = ex_q.pc;
  assign ex_ctrl  = ex_q.ctrl;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline stage that sits directly downstream of the register file. It takes the register file's two combinational read operands and merges them with a same-cycle write-back bypass, because the register file commits on the clock edge and would otherwise return stale data. It also detects load-use hazards and registers the decoded instruction into the EX stage, with stall, flush and bubble insertion.

## Interface
Parameters:
- XLEN, 32, datapath width
- AW, 5, register index width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  reset, asynchronous, active-high
- stall  in  1  downstream stall: hold EX register contents
- flush  in  1  branch/exception flush: kill instruction entering EX
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2, id_rd  in  AW  decoded register indices
- id_use_rs1, id_use_rs2  in  1  instruction actually reads rs1/rs2
- id_imm, id_pc  in  XLEN  immediate, instruction PC
- id_ctrl  in  9  {regWrite, memRead, memWrite, memToReg, aluSrc, aluOp[3:0]}
- rf_rdata1, rf_rdata2  in  XLEN  register-file read data for id_rs1/id_rs2
- wb_regWrite  in  1  write-back enable (same signal driving the register-file write port)
- wb_rd  in  AW  write-back destination
- wb_data  in  XLEN  write-back value
- hazard_stall  out  1  combinational: freeze PC and IF/ID this cycle
- ex_valid  out  1  EX holds a real instruction
- ex_rs1, ex_rs2, ex_rd  out  AW  registered indices
- ex_op1, ex_op2  out  XLEN  registered bypassed operands
- ex_imm, ex_pc  out  XLEN  registered immediate, PC
- ex_ctrl  out  9  registered control; forced 0 when not valid

## Operation
- Bypass, per operand n:
  - If wb_regWrite && wb_rd != 0 && wb_rd == id_rsn, then opn = wb_data.
  - Else if id_rsn == 0, then opn = 0.
  - Else opn = rf_rdatan.
- Hazard: hazard_stall = id_valid && ex_valid && ex_ctrl.memRead && ex_rd != 0 && ((id_use_rs1 && ex_rd == id_rs1) || (id_use_rs2 && ex_rd == id_rs2)).
- EX register update priority, evaluated at each posedge:
  1. reset (async): all ex_* = 0.
  2. flush: ex_valid = 0, ex_ctrl = 0. Flush overrides stall.
  3. stall: all ex_* hold.
  4. hazard_stall: insert a bubble (ex_valid = 0, ex_ctrl = 0). The ID instruction is retained upstream and re-presented next cycle.
  5. Otherwise load: ex_valid = id_valid, with all fields captured. ex_ctrl = id_valid ? id_ctrl : 0.
- Data fields of a bubble are don't-care, but the implementation zeroes them for determinism.
- hazard_stall is a pure function of the current inputs and EX state. It does not depend on stall or flush; the upstream gating logic is responsible for combining them.

## Timing
- Latency: one cycle from ID inputs to ex_* outputs.
- Bypass and hazard paths are combinational within the ID cycle; there are no extra registers on them.
- Reset: asynchronous assert, synchronous deassert assumed. ex_valid = 0 and all ex_* = 0 during reset and after it. hazard_stall = 0 while reset is held, since ex_valid = 0.
- Reset asserted mid-stall or mid-hazard: the EX state is cleared immediately, and the first edge after release loads normally.
- Simultaneous write-back and read of the same register: the bypass value wins, so an ID read sees the value being written this edge.
- Write-back to x0 is never bypassed; an x0 operand is always 0.
- A load-use hazard lasts exactly one cycle. After the bubble, ex_memRead = 0, so hazard_stall drops and the dependent instruction's operand is obtained via the WB bypass two cycles later, or via EX/MEM forwarding, which is outside this block.
- stall with a hazard present: EX holds and hazard_stall stays asserted.
- Back-to-back flushes: each edge produces a bubble.

## Test plan
- Reset mid-run:
  - Stimulus: load valid instruction (rd=5, ctrl=0x1FF), then assert reset for 3 cycles.
  - Required: ex_valid=0, ex_ctrl=0, ex_op1=0 immediately on reset, and after release the next ID instruction loads on the first edge.
- Bypass:
  - Stimulus: rs1=7, rf_rdata1=0x11, wb_regWrite=1, wb_rd=7, wb_data=0xDEADBEEF.
  - Required: ex_op1=0xDEADBEEF next cycle, and ex_op1=0x11 when wb_rd=8.
- x0:
  - Stimulus: rs2=0, rf_rdata2=0x55, wb_rd=0, wb_data=0x99.
  - Required: ex_op2=0.
- Load-use:
  - Stimulus: EX holds a load with rd=3; ID has rs1=3, use_rs1=1.
  - Required: hazard_stall=1 for one cycle, one bubble enters EX (ex_valid=0), then the dependent instruction loads with hazard_stall=0.
  - Repeat with use_rs1=0: required hazard_stall=0.
- Stall/flush:
  - Stimulus: stall=1 for 4 cycles with changing ID inputs.
  - Required: ex_* unchanged.
  - Stimulus: stall=1 and flush=1 together.
  - Required: ex_valid=0 next edge.
- Random regression:
  - Stimulus: 10k random cycles against a reference model of the priority list.
  - Required: ex_ctrl==0 whenever ex_valid==0.
